// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional build macro FAST_MUL_EN: multiplies use a single-cycle combinational product.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op;
    logic            a_neg;
    logic            b_neg;
    logic            short_hit;
    logic [XLEN-1:0] short_val;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] opnd;

    // Launch-time decode of the incoming operands.
    logic            in_mul;
    logic            in_a_signed;
    logic            in_b_signed;
    logic            in_a_neg;
    logic            in_b_neg;
    logic [XLEN-1:0] in_a_mag;
    logic [XLEN-1:0] in_b_mag;
    logic            in_div_zero;
    logic            in_ovf;
    logic [XLEN-1:0] in_short_val;

    always_comb begin
        in_mul       = ~funct3[2];
        in_a_signed  = in_mul ? (funct3 != 3'd3) : ~funct3[0];
        in_b_signed  = in_mul ? ~funct3[1] : ~funct3[0];
        in_a_neg     = in_a_signed & SrcA[XLEN-1];
        in_b_neg     = in_b_signed & SrcB[XLEN-1];
        in_a_mag     = in_a_neg ? (~SrcA + 1'b1) : SrcA;
        in_b_mag     = in_b_neg ? (~SrcB + 1'b1) : SrcB;
        in_div_zero  = ~in_mul & (SrcB == '0);
        in_ovf       = ~in_mul & ~funct3[0] & (SrcA == MIN_NEG) & (SrcB == '1);
        // funct3[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
        if (in_div_zero)
            in_short_val = funct3[1] ? SrcA : '1;
        else
            in_short_val = funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration step of each datapath.
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_tmp;
    logic            div_ge;
    logic [XLEN-1:0] div_sub;

    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        div_tmp = {hi, lo[XLEN-1]};
        div_ge  = (div_tmp >= {1'b0, opnd});
        div_sub = div_tmp[XLEN-1:0] - opnd;
    end

    // Sign fix-up and output selection at the end of an operation.
    logic [2*XLEN-1:0] mul_mag;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_val;
    logic              fast_done;

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    // On the first CALC cycle lo still holds |B| and opnd holds |A|.
    assign fast_prod = {{XLEN{1'b0}}, opnd} * {{XLEN{1'b0}}, lo};
    assign mul_mag   = fast_prod;
    assign fast_done = ~op[2];
`else
    assign mul_mag   = {hi, lo};
    assign fast_done = 1'b0;
`endif

    always_comb begin
        prod_s = (a_neg ^ b_neg) ? (~mul_mag + 1'b1) : mul_mag;
        quo    = (a_neg ^ b_neg) ? (~lo + 1'b1) : lo;
        rem    = a_neg ? (~hi + 1'b1) : hi;
        if (short_hit)
            final_val = short_val;
        else if (~op[2])
            final_val = (op[1:0] == 2'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        else
            final_val = op[1] ? rem : quo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            short_hit <= 1'b0;
            short_val <= '0;
            hi        <= '0;
            lo        <= '0;
            opnd      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            Result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CALC;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        op        <= funct3;
                        a_neg     <= in_a_neg;
                        b_neg     <= in_b_neg;
                        short_hit <= in_div_zero | in_ovf;
                        short_val <= in_short_val;
                        hi        <= '0;
                        // Multiply: lo = multiplier, opnd = multiplicand.
                        // Divide:   lo = dividend (becomes quotient), opnd = divisor.
                        lo        <= in_mul ? in_b_mag : in_a_mag;
                        opnd      <= in_mul ? in_a_mag : in_b_mag;
                    end
                end
                CALC: begin
                    if (short_hit || fast_done || cnt == CW'(XLEN)) begin
                        Result <= final_val;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        if (~op[2]) begin
                            hi <= mul_sum[XLEN:1];
                            lo <= {mul_sum[0], lo[XLEN-1:1]};
                        end else begin
                            hi <= div_ge ? div_sub : div_tmp[XLEN-1:0];
                            lo <= {lo[XLEN-2:0], div_ge};
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative RV32M multiply/divide unit. Sits directly downstream of the register file.
- Consumes the RD1/RD2 operand pair (driven as SrcA/SrcB) and produces a 32-bit result for the writeback mux that feeds WD3.
- Control stalls the core with busy. It asserts WE3 for the M-instruction only in the cycle where done=1.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported; the parameter documents the width and sizes the internal iteration counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch request; sampled only in IDLE
- funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- SrcA  input  XLEN  rs1 operand (from RD1)
- SrcB  input  XLEN  rs2 operand (from RD2)
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; Result is valid in this cycle
- Result  output  XLEN  registered result; holds until the next accepted start or reset

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE; busy=0, done=0, Result=0; all internal registers cleared.
  - The operation in flight is discarded, with no partial result.
- States and transitions:
  - IDLE -> CALC when start=1 at edge E0. funct3, SrcA and SrcB are latched at E0; later input changes are ignored.
  - CALC runs 32 iterations, one per edge (E1..E32), then enters DONE at E33.
  - DONE lasts one cycle (done=1, Result valid) -> IDLE.
- Latency and handshake:
  - Normal operations: done is high in the cycle after E33.
  - Short-circuit cases: CALC is skipped, DONE is entered at E1.
  - start while busy=1 is ignored and not queued.
  - start in the DONE cycle is ignored. The earliest new start is sampled in IDLE, the cycle after done.
- Multiply: shift-add on operand magnitudes, 64-bit accumulator.
  - Sign handling: MUL and MULH treat both operands as signed; MULHSU treats A signed, B unsigned; MULHU treats both unsigned.
  - The product is negated at the end if the signs differ.
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
- Divide: restoring division on magnitudes.
  - DIV and REM are signed; DIVU and REMU are unsigned.
  - Quotient sign = sign(A) XOR sign(B). Remainder takes the sign of the dividend.
  - DIV and DIVU return the quotient; REM and REMU return the remainder.
- Short-circuit cases (per RISC-V spec):
  - Divide by zero: quotient = 0xFFFFFFFF; remainder = SrcA.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Result is written only on entry to DONE. It is unchanged during CALC and IDLE.
- Arithmetic is modulo 2^32 on output; there are no exceptions or flags.

Optional Feature:
- Macro: FAST_MUL_EN.
- Defined:
  - funct3 0-3 use a single-cycle combinational 64-bit signed/unsigned product.
  - IDLE -> DONE at E1, so done follows one cycle after start.
  - Divides remain iterative at 33 edges.
- Undefined: all multiplies use the 32-iteration path, with done after E33.
- Result values are identical in both builds.

Test Plan:
- MUL 7 x -3 (SrcA=7, SrcB=0xFFFFFFFD, funct3=0): busy rises after E0; done in cycle after E33; Result=0xFFFFFFEB; busy=0 after DONE.
- MULH / MULHSU / MULHU with 0x80000000 x 0xFFFFFFFF -> Result=0x00000000 / 0x80000000 / 0x7FFFFFFF.
- DIV -7/2 -> Result=0xFFFFFFFD; REM -7/2 -> Result=0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Short-circuit cases, each with done one cycle after start:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM of the same operands -> 0.
- start pulsed again at E5 with new operands during CALC -> ignored; the first result completes unchanged. Operands changed mid-CALC -> no effect.
- reset asserted asynchronously at E10 of a DIV -> busy, done and Result all 0 immediately. After release, a new MUL 3x4 -> 12.
